// File: rtl/serpent_pkg.sv
// Shared Serpent decrypt definitions: round constants, FSM encoding,
// inverse S-box tables and the bitsliced inverse round primitives.
package serpent_pkg;

  localparam int SERPENT_ROUNDS = 32;
  localparam int SUBKEY_LAST    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MIX   = 2'd2
  } de_state_e;

  // InvS0..InvS7, indexed [box][input nibble]
  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'hD,4'h3,4'hB,4'h0,4'hA,4'h6,4'h5,4'hC,4'h1,4'hE,4'h4,4'h7,4'hF,4'h9,4'h8,4'h2},
    '{4'h5,4'h8,4'h2,4'hE,4'hF,4'h6,4'hC,4'h3,4'hB,4'h4,4'h7,4'h9,4'h1,4'hD,4'hA,4'h0},
    '{4'hC,4'h9,4'hF,4'h4,4'hB,4'hE,4'h1,4'h2,4'h0,4'h3,4'h6,4'hD,4'h5,4'h8,4'hA,4'h7},
    '{4'h0,4'h9,4'hA,4'h7,4'hB,4'hE,4'h6,4'hD,4'h3,4'h5,4'hC,4'h2,4'h4,4'h8,4'hF,4'h1},
    '{4'h5,4'h0,4'h8,4'h3,4'hA,4'h9,4'h7,4'hE,4'h2,4'hC,4'hB,4'h6,4'h4,4'hF,4'hD,4'h1},
    '{4'h8,4'hF,4'h2,4'h9,4'h4,4'h1,4'hD,4'hE,4'hB,4'h6,4'h5,4'h3,4'h7,4'hC,4'hA,4'h0},
    '{4'hF,4'hA,4'h1,4'hD,4'h5,4'h3,4'h6,4'h0,4'h4,4'h9,4'hE,4'h7,4'h2,4'hC,4'h8,4'hB},
    '{4'h3,4'h0,4'h6,4'hD,4'h9,4'hE,4'hF,4'h8,4'h5,4'hC,4'hB,4'h7,4'hA,4'h1,4'h4,4'h2}
  };

  function automatic logic [31:0] rotr32(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // Inverse linear transform; word 0 is x[31:0], word 3 is x[127:96].
  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    x0 = x[31:0];
    x1 = x[63:32];
    x2 = x[95:64];
    x3 = x[127:96];
    x2 = rotr32(x2, 22);
    x0 = rotr32(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotr32(x3, 7);
    x1 = rotr32(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotr32(x2, 3);
    x0 = rotr32(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  // Column j forms nibble {w3[j],w2[j],w1[j],w0[j]}; w0 is the LSB.
  function automatic logic [127:0] inv_sbox_slice(input logic [127:0] x,
                                                  input logic [2:0]   s);
    logic [127:0] y;
    logic [3:0]   nib;
    logic [3:0]   o;
    y = '0;
    for (int j = 0; j < 32; j++) begin
      nib        = {x[96+j], x[64+j], x[32+j], x[j]};
      o          = INV_SBOX[s][nib];
      y[j]       = o[0];
      y[32+j]    = o[1];
      y[64+j]    = o[2];
      y[96+j]    = o[3];
    end
    return y;
  endfunction

endpackage

// File: rtl/serpent_de_round.sv
// Combinational inverse round: inverse LT (skipped for the last
// encryption round) followed by the round's inverse S-box.
module serpent_de_round
  import serpent_pkg::*;
(
  input  logic [127:0] i_data,
  input  logic [5:0]   i_round,
  output logic [127:0] o_data
);

  logic [127:0] lt_out;

  // Round 31 had no LT on the encrypt side, so it has none to undo here.
  always_comb begin
    lt_out = (i_round == 6'(SERPENT_ROUNDS - 1)) ? i_data : inv_lt(i_data);
    o_data = inv_sbox_slice(lt_out, i_round[2:0]);
  end

endmodule

// File: rtl/serpent_de.sv
// Iterative Serpent block decryptor, bitslice domain (no IP/FP).
// Walks subkeys K32..K0, spending one FETCH and one MIX cycle per key.
module serpent_de
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic         i_subkey_valid,
  input  logic [127:0] i_key,
  input  logic [127:0] i_data,
  output logic [127:0] o_data,
  output logic [5:0]   o_address,
  output logic         o_data_valid,
  output logic         o_busy
);

  de_state_e    state;
  logic [5:0]   r;
  logic [127:0] x;
  logic [127:0] rnd_out;

  serpent_de_round u_round (
    .i_data  (x),
    .i_round (r),
    .o_data  (rnd_out)
  );

  assign o_address = r;
  assign o_busy    = (state != IDLE);

  // Control FSM plus datapath register; the output pulse is registered here.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      r            <= '0;
      x            <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en && i_subkey_valid) begin
            x     <= i_data;
            r     <= 6'(SUBKEY_LAST);
            state <= FETCH;
          end
        end
        FETCH: begin
          if (!i_subkey_valid) begin
            r     <= '0;
            state <= IDLE;
          end else begin
            state <= MIX;
          end
        end
        MIX: begin
          if (!i_subkey_valid) begin
            r     <= '0;
            state <= IDLE;
          end else if (r == 6'(SUBKEY_LAST)) begin
            // Undo the final whitening key before the first inverse round.
            x     <= x ^ i_key;
            r     <= r - 6'd1;
            state <= FETCH;
          end else if (r == 6'd0) begin
            o_data       <= rnd_out ^ i_key;
            o_data_valid <= 1'b1;
            r            <= '0;
            state        <= IDLE;
          end else begin
            x     <= rnd_out ^ i_key;
            r     <= r - 6'd1;
            state <= FETCH;
          end
        end
        default: begin
          r     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
